// File: rtl/icache_dm_if.sv
// icache_dm_if: CPU fetch port and block-memory port of the direct-mapped I-cache.
// Ports: PC/FLUSH in, INSTRUCTION/busywait out (CPU side); mem_read/mem_address out,
//        mem_readdata/mem_busywait in (memory side); hit_count/miss_count with ICACHE_STATS_EN.
// Modports: master = CPU + memory model, slave = cache.
interface icache_dm_if #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ADDR_W          = 10
);
  localparam int OFF_W   = $clog2(WORDS_PER_BLOCK);
  localparam int MADDR_W = ADDR_W - OFF_W - 2;

  logic [31:0]                   PC;
  logic                          FLUSH;
  logic [31:0]                   INSTRUCTION;
  logic                          busywait;
  logic                          mem_read;
  logic [MADDR_W-1:0]            mem_address;
  logic [32*WORDS_PER_BLOCK-1:0] mem_readdata;
  logic                          mem_busywait;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport master (
    output PC, FLUSH, mem_readdata, mem_busywait,
    input  INSTRUCTION, busywait, mem_read, mem_address, hit_count, miss_count
  );
  modport slave (
    input  PC, FLUSH, mem_readdata, mem_busywait,
    output INSTRUCTION, busywait, mem_read, mem_address, hit_count, miss_count
  );
`else
  modport master (
    output PC, FLUSH, mem_readdata, mem_busywait,
    input  INSTRUCTION, busywait, mem_read, mem_address
  );
  modport slave (
    input  PC, FLUSH, mem_readdata, mem_busywait,
    output INSTRUCTION, busywait, mem_read, mem_address
  );
`endif
endinterface

// File: rtl/icache_dm.sv
// icache_dm: parametrised direct-mapped read-only instruction cache with flush.
// Latency: hit returns the word combinationally (0 cycles); miss stalls 1 + N fetch + 1 update cycles.
// Backpressure: busywait stalls the CPU while PC misses or a fill runs; memory stalls us via mem_busywait.
// Ports: CLK, RESET (async active-low), bus (icache_dm_if.slave).
// Optional macro ICACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module icache_dm #(
  parameter int NUM_LINES       = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ADDR_W          = 10
) (
  input  logic         CLK,
  input  logic         RESET,
  icache_dm_if.slave   bus
);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int OFF_W   = $clog2(WORDS_PER_BLOCK);
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W - 2;
  localparam int MADDR_W = ADDR_W - OFF_W - 2;
  localparam int BLK_W   = 32 * WORDS_PER_BLOCK;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  logic [1:0]           state;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [BLK_W-1:0]     data_mem [NUM_LINES];
  logic [MADDR_W-1:0]   maddr_q;
  logic [BLK_W-1:0]     fill_buf;
  logic                 flush_pend;

  // Address decode of the current PC; bits above ADDR_W alias away.
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [MADDR_W-1:0] pc_maddr;
  logic [31:0]        word_sel;
  logic [BLK_W-1:0]   line_blk;
  logic               hit;
  logic               unused_pc;

  assign idx       = bus.PC[OFF_W+2 +: IDX_W];
  assign tag       = bus.PC[ADDR_W-1 -: TAG_W];
  assign pc_maddr  = bus.PC[OFF_W+2 +: MADDR_W];
  // Arithmetic select keeps WORDS_PER_BLOCK == 1 (no offset field) legal.
  assign word_sel  = (bus.PC >> 2) & 32'(WORDS_PER_BLOCK - 1);
  assign line_blk  = data_mem[idx];
  assign unused_pc = ^bus.PC;

  assign hit = (state == S_IDLE) && valid[idx] && (tag_mem[idx] == tag);

  assign bus.INSTRUCTION = hit ? line_blk[word_sel*32 +: 32] : 32'd0;
  // Gated by RESET so the stall is released the moment reset is asserted.
  assign bus.busywait    = RESET ? !hit : 1'b0;
  assign bus.mem_read    = (state == S_FETCH);
  assign bus.mem_address = maddr_q;

  // Refill target comes from the latched block address, not the live PC.
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  assign fill_idx = maddr_q[IDX_W-1:0];
  assign fill_tag = maddr_q[MADDR_W-1:IDX_W];

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= S_IDLE;
      valid      <= '0;
      maddr_q    <= '0;
      fill_buf   <= '0;
      flush_pend <= 1'b0;
`ifdef ICACHE_STATS_EN
      hit_cnt    <= '0;
      miss_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // A flush still lets this cycle's hit complete; only the valid bits clear.
          if (bus.FLUSH) valid <= '0;
          if (!hit) begin
            state   <= S_FETCH;
            maddr_q <= pc_maddr;
`ifdef ICACHE_STATS_EN
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
          end else begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
`endif
          end
        end
        S_FETCH: begin
          if (bus.FLUSH) flush_pend <= 1'b1;
          if (!bus.mem_busywait) begin
            fill_buf <= bus.mem_readdata;
            state    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          // A flush seen during the fill also kills the line just installed.
          if (flush_pend || bus.FLUSH) valid <= '0;
          else                         valid[fill_idx] <= 1'b1;
          flush_pend <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag/data arrays need no reset; the valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (state == S_UPDATE) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_buf;
    end
  end
endmodule
